// File: rtl/pipelined_control_unit.sv
// Decodes an opcode and carries its control fields down a DEPTH-stage pipe.
// Latency: PC_Src 0 cycles, ALU_Op/ALU_Valid EX_IDX cycles, Reg_Write WB_IDX cycles.
// Backpressure: In_Ready drops on Stall, Flush or an active jump shadow; stages never hold.
module pipelined_control_unit #(
    parameter int OPW    = 2,
    parameter int ALUW   = 1,
    parameter int DEPTH  = 3,
    parameter int EX_IDX = 2,
    parameter int WB_IDX = 3,
    parameter int SHADOW = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPW-1:0]   Opcode,
    input  logic             In_Valid,
    input  logic             Stall,
    input  logic             Flush,
    output logic             In_Ready,
    output logic             PC_Src,
    output logic [ALUW-1:0]  ALU_Op,
    output logic             ALU_Valid,
    output logic             Reg_Write,
    output logic [CNT_W-1:0] Retire_Cnt
);

    typedef struct packed {
        logic            valid;
        logic [ALUW-1:0] alu_op;
        logic            reg_write;
    } stage_t;

    // Index 0 holds S[1]; index DEPTH-1 holds S[DEPTH].
    stage_t           stage_q [DEPTH];
    stage_t           stage_d [DEPTH];
    logic [2:0]       shadow_q;
    logic [2:0]       shadow_d;
    logic [CNT_W-1:0] retire_q;
    logic [CNT_W-1:0] retire_d;

    logic             jump;
    logic             accept;
    logic [ALUW-1:0]  dec_alu_op;
    logic             dec_reg_write;

    // Decode: an all-ones opcode is a jump, which neither writes nor drives the ALU.
    always_comb begin
        jump          = &Opcode;
        dec_alu_op    = '0;
        dec_reg_write = 1'b0;
        if (!jump) begin
            dec_alu_op    = Opcode[ALUW-1:0];
            dec_reg_write = 1'b1;
        end
    end

    // Reset gating keeps the handshake quiet while the pipe is being cleared.
    assign In_Ready = reset & ~Stall & ~Flush & (shadow_q == 3'd0);
    assign accept   = In_Valid & In_Ready;
    assign PC_Src   = accept & jump;

    // Next-state for the pipe: S[1] takes the decode or a bubble, Flush kills up to EX.
    always_comb begin
        stage_d[0] = '0;
        if (accept) begin
            stage_d[0].valid     = 1'b1;
            stage_d[0].alu_op    = dec_alu_op;
            stage_d[0].reg_write = dec_reg_write;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (Flush && (k < EX_IDX)) begin
                stage_d[k] = '0;
            end else begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    // Jump shadow: Flush wins, then a fresh jump reloads, otherwise count down to zero.
    always_comb begin
        shadow_d = shadow_q;
        if (Flush) begin
            shadow_d = 3'd0;
        end else if (accept && jump) begin
            shadow_d = 3'(SHADOW);
        end else if (shadow_q != 3'd0) begin
            shadow_d = shadow_q - 3'd1;
        end
    end

    // Retire counter advances on every valid instruction leaving WB, wrapping naturally.
    always_comb begin
        retire_d = retire_q + {{(CNT_W-1){1'b0}}, stage_q[WB_IDX-1].valid};
    end

    // State registers, all cleared asynchronously so in-flight work is discarded on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            shadow_q <= 3'd0;
            retire_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
            shadow_q <= shadow_d;
            retire_q <= retire_d;
        end
    end

    assign ALU_Op     = stage_q[EX_IDX-1].alu_op;
    assign ALU_Valid  = stage_q[EX_IDX-1].valid;
    assign Reg_Write  = stage_q[WB_IDX-1].valid & stage_q[WB_IDX-1].reg_write;
    assign Retire_Cnt = retire_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit at default parameters.
// Cycle n is the interval after the n-th rising edge of a test; inputs change at edge+1.
// Outputs are sampled at edge+2, well away from the active edge.
module tb_pipelined_control_unit;

    logic       clk;
    logic       reset;
    logic [1:0] Opcode;
    logic       In_Valid;
    logic       Stall;
    logic       Flush;
    logic       In_Ready;
    logic       PC_Src;
    logic [0:0] ALU_Op;
    logic       ALU_Valid;
    logic       Reg_Write;
    logic [7:0] Retire_Cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_retire = 8'd0;

    pipelined_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .Opcode     (Opcode),
        .In_Valid   (In_Valid),
        .Stall      (Stall),
        .Flush      (Flush),
        .In_Ready   (In_Ready),
        .PC_Src     (PC_Src),
        .ALU_Op     (ALU_Op),
        .ALU_Valid  (ALU_Valid),
        .Reg_Write  (Reg_Write),
        .Retire_Cnt (Retire_Cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; In_Valid = 1'b1; Opcode = 2'b11; Stall = 1'b0; Flush = 1'b0;
        #2;
        checks++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", In_Ready); end
        checks++; if (PC_Src !== 1'b0) begin errors++; $display("FAIL reset_pc_src: got %b expected 0", PC_Src); end
        checks++; if (ALU_Op !== 1'b0) begin errors++; $display("FAIL reset_alu_op: got %b expected 0", ALU_Op); end
        checks++; if (ALU_Valid !== 1'b0) begin errors++; $display("FAIL reset_alu_valid: got %b expected 0", ALU_Valid); end
        checks++; if (Reg_Write !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %b expected 0", Reg_Write); end
        checks++; if (Retire_Cnt !== 8'd0) begin errors++; $display("FAIL reset_retire: got %0d expected 0", Retire_Cnt); end
        tick();
        reset = 1'b1; In_Valid = 1'b0; Opcode = 2'b00;
        #1;
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", In_Ready); end
    endtask

    task automatic test_add();
        tick(); // cycle 0
        In_Valid = 1'b1; Opcode = 2'b01; #1;
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b expected 1", In_Ready); end
        checks++; if (PC_Src !== 1'b0) begin errors++; $display("FAIL add_pc_src: got %b expected 0", PC_Src); end
        tick(); // cycle 1
        In_Valid = 1'b0; #1;
        checks++; if (ALU_Valid !== 1'b0) begin errors++; $display("FAIL add_alu_valid_c1: got %b expected 0", ALU_Valid); end
        tick(); // cycle 2
        #1;
        checks++; if (ALU_Valid !== 1'b1) begin errors++; $display("FAIL add_alu_valid_c2: got %b expected 1", ALU_Valid); end
        checks++; if (ALU_Op !== 1'b1) begin errors++; $display("FAIL add_alu_op_c2: got %b expected 1", ALU_Op); end
        checks++; if (Reg_Write !== 1'b0) begin errors++; $display("FAIL add_reg_write_c2: got %b expected 0", Reg_Write); end
        tick(); // cycle 3
        #1;
        checks++; if (Reg_Write !== 1'b1) begin errors++; $display("FAIL add_reg_write_c3: got %b expected 1", Reg_Write); end
        checks++; if (Retire_Cnt !== exp_retire) begin errors++; $display("FAIL add_retire_c3: got %0d expected %0d", Retire_Cnt, exp_retire); end
        tick(); // cycle 4
        #1;
        exp_retire = exp_retire + 8'd1;
        checks++; if (Retire_Cnt !== exp_retire) begin errors++; $display("FAIL add_retire_c4: got %0d expected %0d", Retire_Cnt, exp_retire); end
        checks++; if (Reg_Write !== 1'b0) begin errors++; $display("FAIL add_reg_write_c4: got %b expected 0", Reg_Write); end
    endtask

    task automatic test_jump();
        tick(); // cycle 0: jump
        In_Valid = 1'b1; Opcode = 2'b11; #1;
        checks++; if (PC_Src !== 1'b1) begin errors++; $display("FAIL jump_pc_src: got %b expected 1", PC_Src); end
        tick(); // cycle 1: shadow blocks the add
        Opcode = 2'b01; #1;
        checks++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL jump_shadow_ready: got %b expected 0", In_Ready); end
        checks++; if (PC_Src !== 1'b0) begin errors++; $display("FAIL jump_shadow_pc_src: got %b expected 0", PC_Src); end
        tick(); // cycle 2: add accepted, jump at EX
        #1;
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL jump_after_shadow_ready: got %b expected 1", In_Ready); end
        checks++; if (ALU_Valid !== 1'b1 || ALU_Op !== 1'b0) begin errors++; $display("FAIL jump_ex: got valid %b op %b expected valid 1 op 0", ALU_Valid, ALU_Op); end
        tick(); // cycle 3: jump at WB
        In_Valid = 1'b0; #1;
        checks++; if (Reg_Write !== 1'b0) begin errors++; $display("FAIL jump_reg_write: got %b expected 0", Reg_Write); end
        tick(); // cycle 4
        #1;
        exp_retire = exp_retire + 8'd1;
        checks++; if (Retire_Cnt !== exp_retire) begin errors++; $display("FAIL jump_retire: got %0d expected %0d", Retire_Cnt, exp_retire); end
        checks++; if (ALU_Valid !== 1'b1 || ALU_Op !== 1'b1) begin errors++; $display("FAIL jump_add_ex: got valid %b op %b expected valid 1 op 1", ALU_Valid, ALU_Op); end
        tick(); // cycle 5
        #1;
        checks++; if (Reg_Write !== 1'b1) begin errors++; $display("FAIL jump_add_wb: got %b expected 1", Reg_Write); end
        tick(); // cycle 6
        #1;
        exp_retire = exp_retire + 8'd1;
        checks++; if (Retire_Cnt !== exp_retire) begin errors++; $display("FAIL jump_add_retire: got %0d expected %0d", Retire_Cnt, exp_retire); end
    endtask

    task automatic test_stall();
        tick(); // cycle 0
        Stall = 1'b1; In_Valid = 1'b1; Opcode = 2'b00; #1;
        checks++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL stall_ready_c0: got %b expected 0", In_Ready); end
        tick(); // cycle 1
        #1;
        checks++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL stall_ready_c1: got %b expected 0", In_Ready); end
        tick(); // cycle 2: stall drops, mov accepted; two bubbles ahead of it
        Stall = 1'b0; #1;
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b expected 1", In_Ready); end
        checks++; if (ALU_Valid !== 1'b0) begin errors++; $display("FAIL stall_bubble_ex: got %b expected 0", ALU_Valid); end
        tick(); // cycle 3
        In_Valid = 1'b0; #1;
        checks++; if (Reg_Write !== 1'b0) begin errors++; $display("FAIL stall_bubble_wb: got %b expected 0", Reg_Write); end
        tick(); // cycle 4
        #1;
        checks++; if (ALU_Valid !== 1'b1 || ALU_Op !== 1'b0) begin errors++; $display("FAIL stall_mov_ex: got valid %b op %b expected valid 1 op 0", ALU_Valid, ALU_Op); end
        tick(); // cycle 5: three cycles after stall dropped
        #1;
        checks++; if (Reg_Write !== 1'b1) begin errors++; $display("FAIL stall_mov_wb: got %b expected 1", Reg_Write); end
        tick(); // cycle 6
        #1;
        exp_retire = exp_retire + 8'd1;
        checks++; if (Retire_Cnt !== exp_retire) begin errors++; $display("FAIL stall_retire: got %0d expected %0d", Retire_Cnt, exp_retire); end
    endtask

    task automatic test_flush();
        // Flush while the add sits in S[1]: it is killed.
        tick(); // cycle 0
        In_Valid = 1'b1; Opcode = 2'b01; #1;
        tick(); // cycle 1
        In_Valid = 1'b0; Flush = 1'b1; #1;
        checks++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", In_Ready); end
        tick(); // cycle 2
        Flush = 1'b0; #1;
        checks++; if (ALU_Valid !== 1'b0) begin errors++; $display("FAIL flush_alu_valid: got %b expected 0", ALU_Valid); end
        tick(); // cycle 3
        #1;
        checks++; if (Reg_Write !== 1'b0) begin errors++; $display("FAIL flush_reg_write: got %b expected 0", Reg_Write); end
        tick(); // cycle 4
        #1;
        checks++; if (Retire_Cnt !== exp_retire) begin errors++; $display("FAIL flush_retire: got %0d expected %0d", Retire_Cnt, exp_retire); end
        // Flush while the add sits in S[EX]: it still advances to WB.
        tick(); // cycle 0
        In_Valid = 1'b1; Opcode = 2'b01; #1;
        tick(); // cycle 1
        In_Valid = 1'b0; #1;
        tick(); // cycle 2
        Flush = 1'b1; #1;
        checks++; if (ALU_Valid !== 1'b1) begin errors++; $display("FAIL flush_late_ex: got %b expected 1", ALU_Valid); end
        tick(); // cycle 3
        Flush = 1'b0; #1;
        checks++; if (Reg_Write !== 1'b1) begin errors++; $display("FAIL flush_late_wb: got %b expected 1", Reg_Write); end
        tick(); // cycle 4
        #1;
        exp_retire = exp_retire + 8'd1;
        checks++; if (Retire_Cnt !== exp_retire) begin errors++; $display("FAIL flush_late_retire: got %0d expected %0d", Retire_Cnt, exp_retire); end
    endtask

    task automatic test_flush_stall_jump();
        tick(); // cycle 0
        Flush = 1'b1; Stall = 1'b1; In_Valid = 1'b1; Opcode = 2'b11; #1;
        checks++; if (PC_Src !== 1'b0) begin errors++; $display("FAIL fsj_pc_src: got %b expected 0", PC_Src); end
        checks++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL fsj_ready: got %b expected 0", In_Ready); end
        tick(); // cycle 1: no shadow left behind
        Flush = 1'b0; Stall = 1'b0; In_Valid = 1'b0; Opcode = 2'b00; #1;
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL fsj_no_shadow: got %b expected 1", In_Ready); end
        tick(); // cycle 2
        #1;
        checks++; if (ALU_Valid !== 1'b0) begin errors++; $display("FAIL fsj_no_ex: got %b expected 0", ALU_Valid); end
    endtask

    task automatic test_reset_mid();
        tick(); // cycle 0
        In_Valid = 1'b1; Opcode = 2'b01; #1;
        tick(); // cycle 1
        tick(); // cycle 2
        tick(); // cycle 3: S1..S3 valid
        In_Valid = 1'b0; #1;
        checks++; if (Reg_Write !== 1'b1 || ALU_Valid !== 1'b1) begin errors++; $display("FAIL mid_inflight: got rw %b av %b expected 1 1", Reg_Write, ALU_Valid); end
        reset = 1'b0; #1;
        exp_retire = 8'd0;
        checks++; if ({In_Ready, PC_Src, ALU_Op, ALU_Valid, Reg_Write} !== 5'b0) begin errors++; $display("FAIL mid_outputs: got %b expected 00000", {In_Ready, PC_Src, ALU_Op, ALU_Valid, Reg_Write}); end
        checks++; if (Retire_Cnt !== 8'd0) begin errors++; $display("FAIL mid_retire: got %0d expected 0", Retire_Cnt); end
        tick(); // cycle 4: release, accept immediately
        reset = 1'b1; In_Valid = 1'b1; Opcode = 2'b01; #1;
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %b expected 1", In_Ready); end
        tick(); // cycle 5
        In_Valid = 1'b0; #1;
        checks++; if (ALU_Valid !== 1'b0) begin errors++; $display("FAIL mid_discarded_ex: got %b expected 0", ALU_Valid); end
        tick(); // cycle 6
        #1;
        checks++; if (ALU_Valid !== 1'b1) begin errors++; $display("FAIL mid_first_accept_ex: got %b expected 1", ALU_Valid); end
        tick(); // cycle 7
        #1;
        checks++; if (Reg_Write !== 1'b1) begin errors++; $display("FAIL mid_first_accept_wb: got %b expected 1", Reg_Write); end
        tick(); // cycle 8
        #1;
        exp_retire = exp_retire + 8'd1;
        checks++; if (Retire_Cnt !== exp_retire) begin errors++; $display("FAIL mid_retire_after: got %0d expected %0d", Retire_Cnt, exp_retire); end
    endtask

    task automatic test_back_to_back_wrap();
        tick();
        reset = 1'b0; In_Valid = 1'b0; #1;
        tick();
        reset = 1'b1; #1;
        for (int c = 0; c < 260; c++) begin
            tick();
            In_Valid = (c < 256); Opcode = 2'b01; #1;
            if (c == 100) begin
                checks++; if (In_Ready !== 1'b1 || Reg_Write !== 1'b1) begin errors++; $display("FAIL b2b_stream: got ready %b rw %b expected 1 1", In_Ready, Reg_Write); end
                checks++; if (Retire_Cnt !== 8'd97) begin errors++; $display("FAIL b2b_count: got %0d expected 97", Retire_Cnt); end
            end
            if (c == 258) begin
                checks++; if (Retire_Cnt !== 8'd255) begin errors++; $display("FAIL wrap_pre: got %0d expected 255", Retire_Cnt); end
            end
            if (c == 259) begin
                checks++; if (Retire_Cnt !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", Retire_Cnt); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_jump();
        test_stall();
        test_flush();
        test_flush_stall_jump();
        test_reset_mid();
        test_back_to_back_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 SHALL have parameter OPW, default 2, meaning opcode width (>=2).
REQ-002 SHALL have parameter ALUW, default 1, meaning ALU_Op width (1..OPW).
REQ-003 SHALL have parameter DEPTH, default 3, meaning number of control pipeline stages S[1..DEPTH].
REQ-004 SHALL have parameter EX_IDX, default 2, meaning stage tapped for ALU_Op (1..WB_IDX).
REQ-005 SHALL have parameter WB_IDX, default 3, meaning stage tapped for Reg_Write (EX_IDX..DEPTH).
REQ-006 SHALL have parameter SHADOW, default 1, meaning cycles blocked after an accepted jump (0..7).
REQ-007 SHALL have parameter CNT_W, default 8, meaning retire counter width.
REQ-008 SHALL have port clk  input  1  sole clock, rising edge.
REQ-009 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-010 SHALL have port Opcode  input  OPW  decode-stage opcode.
REQ-011 SHALL have port In_Valid  input  1  Opcode is a real instruction.
REQ-012 SHALL have port Stall  input  1  hazard stall, refuse current instruction.
REQ-013 SHALL have port Flush  input  1  kill in-flight stages up to EX_IDX.
REQ-014 SHALL have port In_Ready  output  1  instruction accepted this cycle if In_Valid.
REQ-015 SHALL have port PC_Src  output  1  accepted jump, select jump target.
REQ-016 SHALL have port ALU_Op  output  ALUW  ALU control at EX stage.
REQ-017 SHALL have port ALU_Valid  output  1  S[EX_IDX] holds valid instruction.
REQ-018 SHALL have port Reg_Write  output  1  register-file write enable at WB stage.
REQ-019 SHALL have port Retire_Cnt  output  CNT_W  count of instructions passing WB.

Function
REQ-020 SHALL decode: jump = (Opcode == all ones); jump -> reg_write 0, alu_op 0; otherwise reg_write 1, alu_op = Opcode[ALUW-1:0].
REQ-021 SHALL drive In_Ready = ~Stall & ~Flush & (shadow_cnt == 0), combinationally.
REQ-022 SHALL define accept = In_Valid & In_Ready.
REQ-023 SHALL drive PC_Src = accept & jump, combinationally, same cycle (zero latency).
REQ-024 SHALL hold per stage {valid, alu_op, reg_write}; each clock S[k] <= S[k-1] for k>=2, S[1] <= decoded fields with valid = accept.
REQ-025 SHALL load a bubble (valid 0, fields 0) into S[1] whenever accept is 0 (stall, flush, shadow, or In_Valid low).
REQ-026 SHALL on Flush clear S[1..EX_IDX] to bubble at the clock edge while stages above EX_IDX advance normally.
REQ-027 SHALL give Flush priority over Stall and over a simultaneous jump; a flushed cycle never asserts PC_Src.
REQ-028 SHALL drive ALU_Op = S[EX_IDX].alu_op, ALU_Valid = S[EX_IDX].valid, Reg_Write = S[WB_IDX].valid & S[WB_IDX].reg_write; latencies EX_IDX and WB_IDX cycles from accept.
REQ-029 SHALL load shadow_cnt with SHADOW on an accepted jump, decrement by 1 each clock while nonzero, and clear it to 0 on Flush.
REQ-030 SHALL with SHADOW=0 never block In_Ready after a jump.
REQ-031 SHALL increment Retire_Cnt by 1 each clock in which S[WB_IDX].valid is 1, wrapping from all ones to 0.
REQ-032 SHALL keep Stall from altering stages S[2..DEPTH]; no stage ever holds its value.

Reset
REQ-033 SHALL while reset is low force all stage registers, shadow_cnt and Retire_Cnt to 0, asynchronously.
REQ-034 SHALL while reset is low drive PC_Src 0, In_Ready 0, ALU_Op 0, ALU_Valid 0, Reg_Write 0.
REQ-035 SHALL accept an instruction on the first rising edge after reset deasserts, with mid-operation reset discarding all in-flight instructions.

Verification
REQ-036 SHALL cover: defaults, accept add (01) at cycle 0 -> ALU_Op=1, ALU_Valid=1 at cycle 2; Reg_Write=1 at cycle 3; Retire_Cnt=1 after.
REQ-037 SHALL cover: jump (11) accepted -> PC_Src=1 same cycle, In_Ready=0 next cycle, Reg_Write never asserted for it.
REQ-038 SHALL cover: Stall high with mov (00) for 2 cycles -> In_Ready=0, two bubbles, mov reaches WB 3 cycles after Stall drops.
REQ-039 SHALL cover: add accepted, Flush next cycle -> ALU_Valid stays 0, Reg_Write stays 0, Retire_Cnt unchanged.
REQ-040 SHALL cover: Flush and Stall and jump simultaneously -> PC_Src=0, shadow_cnt=0, In_Ready=0.
REQ-041 SHALL cover: reset low mid-stream with 3 valid in flight -> all outputs 0 immediately; 256 retires at CNT_W=8 -> Retire_Cnt wraps to 0.
